// File: rtl/clock_ui_pkg.sv
// Shared types and default 12 MHz timing for the clock/time-set user-interface blocks.
package clock_ui_pkg;

    // Button conditioner hold state.
    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StHeld      = 2'd1,
        StRepeating = 2'd2
    } btn_state_e;

    localparam int unsigned CLK_HZ           = 12_000_000;
    localparam int unsigned CYCLES_PER_MS    = CLK_HZ / 1000;
    localparam int unsigned DEBOUNCE_MS      = 20;
    localparam int unsigned REPEAT_DELAY_MS  = 500;
    localparam int unsigned REPEAT_PERIOD_MS = 100;

    localparam int unsigned DEBOUNCE_CYCLES_DEF = CYCLES_PER_MS * DEBOUNCE_MS;      // 240000
    localparam int unsigned REPEAT_DELAY_DEF    = CYCLES_PER_MS * REPEAT_DELAY_MS;  // 6000000
    localparam int unsigned REPEAT_PERIOD_DEF   = CYCLES_PER_MS * REPEAT_PERIOD_MS; // 1200000

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with configurable reset value.
module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous input through two flops to settle metastability.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronise, debounce, press/release pulses and long-press repeat.
module button_conditioner
    import clock_ui_pkg::*;
#(
    parameter bit          ACTIVE_HIGH     = 1'b1,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_raw_i,
    output logic btn_level_o,
    output logic press_o,
    output logic release_o,
    output logic repeat_pulse_o,
    output logic held_long_o
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);

    localparam logic [DB_W-1:0]   DbLast     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] DelayLast  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] PeriodLast = HOLD_W'(REPEAT_PERIOD - 1);

    logic btn_norm;
    logic s;

    logic [DB_W-1:0]   db_cnt_q;
    logic              level_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    btn_state_e        state_q;
    logic              press_q;
    logic              release_q;
    logic              repeat_q;
    logic              held_long_q;

    logic accept;
    logic rise_acc;
    logic fall_acc;

    // Normalise polarity so that 1 always means pressed downstream.
    assign btn_norm = ACTIVE_HIGH ? btn_raw_i : ~btn_raw_i;

    sync_2ff #(
        .RESET_VAL (1'b0)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (btn_norm),
        .q_o    (s)
    );

    // Level change is accepted on the edge where the stable count would reach the threshold.
    assign accept   = (s != level_q) && (db_cnt_q == DbLast);
    assign rise_acc = accept & s;
    assign fall_acc = accept & ~s;

    // Debounce: count consecutive cycles that disagree with the accepted level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            db_cnt_q <= '0;
            level_q  <= 1'b0;
        end else if (s == level_q) begin
            db_cnt_q <= '0;
        end else if (accept) begin
            level_q  <= s;
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_q + 1'b1;
        end
    end

    // Hold FSM with registered event pulses; release takes priority over a repeat expiry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            hold_cnt_q  <= '0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            repeat_q    <= 1'b0;
            held_long_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (rise_acc) begin
                        state_q    <= StHeld;
                        hold_cnt_q <= '0;
                        press_q    <= 1'b1;
                    end
                end
                StHeld: begin
                    if (fall_acc) begin
                        state_q     <= StIdle;
                        hold_cnt_q  <= '0;
                        release_q   <= 1'b1;
                        held_long_q <= 1'b0;
                    end else if (REPEAT_EN && (hold_cnt_q == DelayLast)) begin
                        state_q     <= StRepeating;
                        hold_cnt_q  <= '0;
                        repeat_q    <= 1'b1;
                        held_long_q <= 1'b1;
                    end else if (hold_cnt_q != '1) begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                StRepeating: begin
                    if (fall_acc) begin
                        state_q     <= StIdle;
                        hold_cnt_q  <= '0;
                        release_q   <= 1'b1;
                        held_long_q <= 1'b0;
                    end else if (hold_cnt_q == PeriodLast) begin
                        hold_cnt_q <= '0;
                        repeat_q   <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    hold_cnt_q  <= '0;
                    held_long_q <= 1'b0;
                end
            endcase
        end
    end

    assign btn_level_o    = level_q;
    assign press_o        = press_q;
    assign release_o      = release_q;
    assign repeat_pulse_o = repeat_q;
    assign held_long_o    = held_long_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: one active-high repeating instance and one
// active-low instance with auto-repeat disabled.
module tb_button_conditioner;

    logic clk;
    logic rst_n;
    logic raw_a;
    logic raw_b;

    logic level_a, press_a, rel_a, rep_a, long_a;
    logic level_b, press_b, rel_b, rep_b, long_b;

    int tests;
    int fails;

    button_conditioner #(
        .ACTIVE_HIGH     (1'b1),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3),
        .REPEAT_EN       (1'b1)
    ) dut_a (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .btn_raw_i      (raw_a),
        .btn_level_o    (level_a),
        .press_o        (press_a),
        .release_o      (rel_a),
        .repeat_pulse_o (rep_a),
        .held_long_o    (long_a)
    );

    button_conditioner #(
        .ACTIVE_HIGH     (1'b0),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3),
        .REPEAT_EN       (1'b0)
    ) dut_b (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .btn_raw_i      (raw_b),
        .btn_level_o    (level_b),
        .press_o        (press_b),
        .release_o      (rel_b),
        .repeat_pulse_o (rep_b),
        .held_long_o    (long_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        raw_a = 1'b0;
        raw_b = 1'b1;
        rst_n = 1'b0;
        #12;
        check("rst_level", level_a, 1'b0);
        check("rst_press", press_a, 1'b0);
        check("rst_release", rel_a, 1'b0);
        check("rst_repeat", rep_a, 1'b0);
        check("rst_held_long", long_a, 1'b0);
        check("rst_level_b", level_b, 1'b0);
        step();
        rst_n = 1'b1;
        steps(3);

        // 1. Clean press: accepted on edge 6.
        raw_a = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("t1_level_early", level_a, 1'b0);
            check("t1_press_early", press_a, 1'b0);
        end
        step();
        check("t1_level", level_a, 1'b1);
        check("t1_press", press_a, 1'b1);
        check("t1_release", rel_a, 1'b0);

        // 3. Long hold from that press: repeats at +10, +13, +16, +19.
        for (int k = 1; k <= 20; k++) begin
            step();
            check("t3_press_single", press_a, 1'b0);
            check("t3_repeat", rep_a, (k == 10 || k == 13 || k == 16 || k == 19));
            check("t3_held_long", long_a, (k >= 10));
            check("t3_release_none", rel_a, 1'b0);
        end
        raw_a = 1'b0;
        steps(5);
        check("t3_release_early", rel_a, 1'b0);
        check("t3_level_still", level_a, 1'b1);
        step();
        check("t3_release", rel_a, 1'b1);
        check("t3_level_drop", level_a, 1'b0);
        check("t3_held_long_drop", long_a, 1'b0);
        check("t3_release_press", press_a, 1'b0);
        step();
        check("t3_release_single", rel_a, 1'b0);
        steps(3);

        // 2. Bounce rejection: 3 high, 2 low, 3 high, then low.
        raw_a = 1'b1; steps(3);
        raw_a = 1'b0; steps(2);
        raw_a = 1'b1; steps(3);
        raw_a = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("t2_level", level_a, 1'b0);
            check("t2_press", press_a, 1'b0);
            check("t2_release", rel_a, 1'b0);
        end

        // 4. Release lands on the edge of the second repeat (press+13).
        raw_a = 1'b1;
        steps(6);
        check("t4_press", press_a, 1'b1);
        steps(7);
        raw_a = 1'b0;
        steps(3);
        check("t4_first_repeat", rep_a, 1'b1);
        check("t4_held_long", long_a, 1'b1);
        steps(3);
        check("t4_release", rel_a, 1'b1);
        check("t4_no_repeat", rep_a, 1'b0);
        check("t4_held_long_drop", long_a, 1'b0);
        step();
        check("t4_after_repeat", rep_a, 1'b0);
        steps(3);

        // 5. Reset mid-hold while repeating.
        raw_a = 1'b1;
        steps(6);
        check("t5_press", press_a, 1'b1);
        steps(11);
        check("t5_repeating", long_a, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_rst_level", level_a, 1'b0);
        check("t5_rst_held_long", long_a, 1'b0);
        check("t5_rst_repeat", rep_a, 1'b0);
        check("t5_rst_press", press_a, 1'b0);
        step();
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("t5_press_early", press_a, 1'b0);
        end
        step();
        check("t5_press_again", press_a, 1'b1);
        check("t5_level_again", level_a, 1'b1);
        raw_a = 1'b0;

        // 6. Active-low instance, auto-repeat disabled.
        check("t6_idle_level", level_b, 1'b0);
        raw_b = 1'b0;
        steps(5);
        check("t6_press_early", press_b, 1'b0);
        step();
        check("t6_press", press_b, 1'b1);
        check("t6_level", level_b, 1'b1);
        for (int k = 1; k <= 30; k++) begin
            step();
            check("t6_no_repeat", rep_b, 1'b0);
            check("t6_no_held_long", long_b, 1'b0);
        end
        raw_b = 1'b1;
        steps(6);
        check("t6_release", rel_b, 1'b1);
        check("t6_level_drop", level_b, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Conditions one raw push-button input for the clock/time-set controller: 2-flop synchroniser, debounce filter, one-cycle press/release pulses, and long-press auto-repeat.
- Sits directly upstream of the set/increment logic. One instance per button (set, inc).
- The controller consumes clean single-cycle `press` and `repeat_pulse` events, so it needs no sampling divider of its own.

Parameters:
- ACTIVE_HIGH, 1, 1 = raw button reads 1 when pressed; 0 = raw button reads 0 when pressed. Inverted before any other logic.
- DEBOUNCE_CYCLES, 240000, consecutive stable synchronised cycles required to accept a level change (20 ms at 12 MHz). Must be >= 1.
- REPEAT_DELAY, 6000000, cycles from press to first auto-repeat (0.5 s). Must be >= 1.
- REPEAT_PERIOD, 1200000, cycles between subsequent auto-repeats (100 ms). Must be >= 1.
- REPEAT_EN, 1, 0 disables auto-repeat: `repeat_pulse` and `held_long` stay 0.

Ports:
- clk  input  1  system clock, 12 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- btn_raw  input  1  raw asynchronous button pin.
- btn_level  output  1  debounced level, 1 = pressed.
- press  output  1  one-cycle pulse on accepted press.
- release  output  1  one-cycle pulse on accepted release.
- repeat_pulse  output  1  one-cycle auto-repeat pulse while held.
- held_long  output  1  high from the first repeat until release.

Behaviour:
- Reset (rst_n low, async): sync flops load the inactive level (0 after polarity normalisation). btn_level, press, release, repeat_pulse, held_long = 0. All counters = 0. State = IDLE.
- Synchroniser: two flops on the polarity-normalised input; `s` is the second flop output. Nothing else samples btn_raw.
- Debounce:
  - Counter `db_cnt`, width $clog2(DEBOUNCE_CYCLES+1).
  - If s == btn_level: db_cnt <= 0.
  - Otherwise db_cnt increments. On the edge where the count would reach DEBOUNCE_CYCLES: btn_level <= s and db_cnt <= 0.
  - Any cycle with s == btn_level restarts the count, so glitches shorter than DEBOUNCE_CYCLES are rejected.
  - Latency from the first clk edge sampling a new raw level to btn_level change: 2 + DEBOUNCE_CYCLES edges.
- press / release:
  - Registered. High for exactly the one cycle in which btn_level first shows the new value.
  - Never both high in the same cycle.
- State machine (updates on the same edge as btn_level):
  - IDLE: btn_level 0. On accepted press -> HELD, hold_cnt <= 0, press pulse.
  - HELD: hold_cnt increments each cycle.
    - When hold_cnt reaches REPEAT_DELAY-1 and REPEAT_EN=1: repeat_pulse, held_long <= 1, hold_cnt <= 0, -> REPEATING.
    - With REPEAT_EN=0, stay in HELD; hold_cnt saturates.
  - REPEATING: hold_cnt increments. When it reaches REPEAT_PERIOD-1: repeat_pulse, hold_cnt <= 0.
  - Accepted release from HELD or REPEATING -> IDLE: release pulse, held_long <= 0, hold_cnt <= 0.
- Timing: first repeat_pulse occurs REPEAT_DELAY cycles after the press cycle; subsequent pulses follow every REPEAT_PERIOD cycles.
- hold_cnt width: $clog2(max(REPEAT_DELAY, REPEAT_PERIOD)+1).
- Boundaries:
  - Release accepted on the same edge a repeat timer expires: release wins; no repeat_pulse that cycle.
  - press is never accompanied by repeat_pulse in the same cycle (REPEAT_DELAY >= 1).
  - Reset mid-hold: outputs drop immediately. If the button is still physically held after reset deasserts, a fresh press is reported 2 + DEBOUNCE_CYCLES edges later.
  - Counters never wrap: db_cnt clears at threshold; hold_cnt clears or saturates.
- No combinational path from btn_raw to any output.

Decomposition:
- Shared package clock_ui_pkg:
  - State typedef enum {IDLE, HELD, REPEATING}.
  - Default timing localparams for 12 MHz: CLK_HZ, DEBOUNCE_MS-derived cycles, REPEAT_DELAY and REPEAT_PERIOD cycle counts, reused by other UI blocks.
- One natural sub-module: sync_2ff (parameterised reset value), also reusable for other asynchronous inputs.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, ACTIVE_HIGH=1 unless noted):
1. Clean press: btn_raw 0->1 before edge 1, held -> btn_level and a single press pulse after edge 6; release 0 throughout.
2. Bounce rejection: btn_raw high for 3 cycles, low 2 cycles, high 3 cycles, then low -> btn_level stays 0; no press or release.
3. Long hold: press, then hold 20 cycles -> repeat_pulse at press+10, +13, +16, +19; held_long high from press+10. After release: one release pulse, held_long 0 in the same cycle.
4. Coincident release: release timed so btn_level falls on the edge where repeat would fire (press+13) -> release pulse only; no repeat_pulse.
5. Reset mid-hold: button held in REPEATING, rst_n pulsed low mid-cycle -> all outputs 0 immediately. Button still held -> new press pulse 6 edges after rst_n rises.
6. Polarity: ACTIVE_HIGH=0, btn_raw 1->0 -> press after 6 edges. REPEAT_EN=0 with a 30-cycle hold -> no repeat_pulse; held_long stays 0.
